axis_lfsr_gen: RTL and testbench
================================

AXIS_LFSR_GEN -- requirements
Module: axis_lfsr_gen

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 8, bits per output beat; LFSR_WIDTH, 8, LFSR state width; TAPS, 8'hB8, LFSR_WIDTH-bit feedback mask; SEED, 8'h2D, LFSR_WIDTH-bit nonzero reset seed; GALOIS, 1, where 1 selects Galois and 0 selects Fibonacci; PACKET_LEN, 0, beats per packet, where 0 means tlast is never asserted.
REQ-002 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-003 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 Port enable, input, 1 bit: allows generation of new beats.
REQ-005 Port seed_load, input, 1 bit: request to reseed.
REQ-006 Port seed_data, input, LFSR_WIDTH bits: runtime seed.
REQ-007 Port seed_ready, output, 1 bit: high when seed_load can be accepted.
REQ-008 Port out, AXI4S master (DATA_WIDTH): tvalid and tdata[DATA_WIDTH-1:0] out; tready in; tlast out.
REQ-009 Elaboration SHALL fail if SEED==0, TAPS==0, or DATA_WIDTH<1.

Function
REQ-010 One LFSR step, Galois: out_bit=s[0]; s_next=(s>>1)^(out_bit ? TAPS : 0).
REQ-011 One LFSR step, Fibonacci: out_bit=s[0]; fb=^(s & TAPS); s_next={fb, s[LFSR_WIDTH-1:1]}.
REQ-012 Each beat SHALL advance the LFSR by exactly DATA_WIDTH steps in one cycle; tdata[i] is out_bit of step i (LSB first).
REQ-013 Output SHALL be registered: tdata and tlast are loaded only when (!tvalid || tready) && enable && !seed_load.
REQ-014 tvalid SHALL rise the cycle after the load condition holds; a beat is transferred on tvalid && tready.
REQ-015 While tvalid && !tready, tdata, tlast and tvalid SHALL be held stable regardless of enable or seed_load.
REQ-016 On handshake with enable=1, the next beat SHALL be loaded in the same cycle (one beat per cycle under continuous tready).
REQ-017 On handshake with enable=0, tvalid SHALL fall the next cycle; the LFSR state holds while idle.
REQ-018 States: IDLE (tvalid=0), VALID (tvalid=1, awaiting tready). IDLE->VALID on the load condition; VALID->IDLE on handshake with no reload; VALID->VALID on handshake with reload or on a stall.
REQ-019 seed_ready SHALL equal !(tvalid && !tready).
REQ-020 When seed_load && seed_ready: state <= (seed_data==0 ? SEED : seed_data); the beat counter clears; no new beat loads that cycle; a beat handshaking that cycle completes normally.
REQ-021 seed_load while seed_ready=0 SHALL be ignored; the requester retries.
REQ-022 Beat counter: range 0..PACKET_LEN-1, increments per loaded beat and wraps to 0; tlast=1 on the beat loaded when counter==PACKET_LEN-1.
REQ-023 An all-zero LFSR state SHALL be unreachable; any zero load is replaced by SEED.
REQ-024 The beat period SHALL be the LFSR period divided by gcd(period, DATA_WIDTH); no sequence reset at wrap.

Reset
REQ-025 Reset SHALL be synchronous, active-high and take priority over every other input.
REQ-026 While reset is high: LFSR state=SEED; tvalid=0; tlast=0; tdata=0; beat counter=0; state machine=IDLE; seed_ready=1.
REQ-027 Reset asserted mid-stall SHALL drop tvalid on the next edge and discard the pending beat.
REQ-028 After reset falls with enable=1 and tready=1: tvalid SHALL be high on the first edge and streaming continues from SEED.

Verification
REQ-029 Defaults, tready=1, enable=1 after reset -> first beat tdata=0x1D; the state after the beat is 0x18.
REQ-030 Defaults, continuous stream -> the tdata sequence repeats with a period of exactly 255 beats; tdata of beat 255 equals beat 0 (0x1D).
REQ-031 tready held low for 5 cycles after tvalid -> tdata=0x1D stable throughout, seed_ready=0, seed_load pulses ignored; one transfer when tready rises.
REQ-032 seed_load=1 with seed_data=0x00 while idle -> state reloads to 0x2D; the next beat is 0x1D. Reseed with 0x2D mid-stream -> the same sequence restarts from 0x1D.
REQ-033 PACKET_LEN=4 -> tlast high on beats 3, 7, 11; a reseed after beat 5 restarts counting, so tlast is high on the 4th beat after the reseed.
REQ-034 enable dropped mid-stream, then reset pulsed during a stall -> tvalid=0 the cycle after reset, counter=0; restart yields first tdata=0x1D.

Source files
------------

// File: rtl/axis_lfsr_gen.sv
// AXI4-Stream pseudo-random beat generator driven by a Galois or Fibonacci LFSR.
// Each beat advances the LFSR by DATA_WIDTH steps. Output is registered. Runtime reseeding is supported. tlast is optional.
module axis_lfsr_gen #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 8'hB8,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 8'h2D,
  parameter int                    GALOIS     = 1,
  parameter int                    PACKET_LEN = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_data,
  output logic                  seed_ready,
  output logic [DATA_WIDTH-1:0] out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tlast
);

  localparam int CNT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (PACKET_LEN > 0) ? CNT_W'(PACKET_LEN - 1) : '0;

  if (SEED == '0 || TAPS == '0 || DATA_WIDTH < 1 || LFSR_WIDTH < 2) begin : g_bad_params
    $error("axis_lfsr_gen: SEED and TAPS must be nonzero, DATA_WIDTH >= 1, LFSR_WIDTH >= 2");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_t;

  state_t                  fsm;
  logic [LFSR_WIDTH-1:0]   lfsr;
  logic [CNT_W-1:0]        beat_cnt;

  logic [LFSR_WIDTH-1:0]   walk;
  logic                    fb;
  logic [DATA_WIDTH-1:0]   step_data;
  logic [LFSR_WIDTH-1:0]   step_state;
  logic [LFSR_WIDTH-1:0]   seed_value;

  logic stall;
  logic load;

  assign stall      = (fsm == VALID) && !out_tready;
  assign seed_ready = !stall;
  assign load       = !stall && enable && !seed_load;
  assign seed_value = (seed_data == '0) ? SEED : seed_data;

  // Unroll DATA_WIDTH LFSR steps. Bit i of the beat is the output bit of step i.
  always_comb begin
    walk      = lfsr;
    fb        = 1'b0;
    step_data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      step_data[i] = walk[0];
      if (GALOIS != 0) begin
        walk = (walk >> 1) ^ (walk[0] ? TAPS : '0);
      end else begin
        fb   = ^(walk & TAPS);
        walk = {fb, walk[LFSR_WIDTH-1:1]};
      end
    end
    step_state = (walk == '0) ? SEED : walk;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm        <= IDLE;
      lfsr       <= SEED;
      beat_cnt   <= '0;
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tlast  <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        fsm        <= VALID;
        out_tvalid <= 1'b1;
        out_tdata  <= step_data;
        lfsr       <= step_state;
        out_tlast  <= (PACKET_LEN != 0) && (beat_cnt == CNT_LAST);
        if (PACKET_LEN != 0) begin
          beat_cnt <= (beat_cnt == CNT_LAST) ? '0 : beat_cnt + CNT_W'(1);
        end
      end else begin
        // A reseed or a disabled cycle loads no beat. Any beat that completes its handshake this cycle still leaves normally.
        if (seed_load) begin
          lfsr     <= seed_value;
          beat_cnt <= '0;
        end
        fsm        <= IDLE;
        out_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_lfsr_gen.sv
// Bench for axis_lfsr_gen: an abstract beat model is checked every cycle for the default build and for a PACKET_LEN=4 build.
module tb_axis_lfsr_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed_data = 8'h00;
  logic       tready = 1'b0;

  logic       seed_ready0, tvalid0, tlast0;
  logic [7:0] tdata0;
  logic       seed_ready4, tvalid4, tlast4;
  logic [7:0] tdata4;

  int tests = 0;
  int fails = 0;

  int m_state = 'h2D;
  int m_valid = 0;
  int m_data  = 0;
  int m_last4 = 0;
  int m_cnt4  = 0;

  always #5 clk = ~clk;

  axis_lfsr_gen dut (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed_data(seed_data), .seed_ready(seed_ready0), .out_tdata(tdata0),
    .out_tvalid(tvalid0), .out_tready(tready), .out_tlast(tlast0)
  );

  axis_lfsr_gen #(.PACKET_LEN(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
    .seed_data(seed_data), .seed_ready(seed_ready4), .out_tdata(tdata4),
    .out_tvalid(tvalid4), .out_tready(tready), .out_tlast(tlast4)
  );

  // Eight Galois steps on an integer state. The data bits come out LSB first.
  function automatic void gen_beat(input int s_in, output int data, output int s_out);
    int s;
    int b;
    s = s_in;
    data = 0;
    for (int i = 0; i < 8; i++) begin
      b = s % 2;
      data = data + (b << i);
      s = s / 2;
      if (b != 0) s = s ^ 'hB8;
    end
    s_out = (s == 0) ? 'h2D : s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int d;
    int ns;
    if (reset) begin
      m_state = 'h2D; m_valid = 0; m_data = 0; m_last4 = 0; m_cnt4 = 0;
    end else if (m_valid != 0 && !tready) begin
      // The beat is stalled, so the model holds everything.
    end else if (enable && !seed_load) begin
      gen_beat(m_state, d, ns);
      m_data  = d;
      m_state = ns;
      m_last4 = (m_cnt4 == 3) ? 1 : 0;
      m_cnt4  = (m_cnt4 + 1) % 4;
      m_valid = 1;
    end else begin
      if (seed_load) begin
        m_state = (seed_data == 8'h00) ? 'h2D : int'(seed_data);
        m_cnt4  = 0;
      end
      m_valid = 0;
    end
  endtask

  task automatic compare_all();
    int exp_ready;
    exp_ready = (m_valid != 0 && !tready) ? 0 : 1;
    check("tvalid", int'(tvalid0), m_valid);
    check("tdata", int'(tdata0), m_data);
    check("tlast_nopkt", int'(tlast0), 0);
    check("seed_ready", int'(seed_ready0), exp_ready);
    check("tvalid_pkt4", int'(tvalid4), m_valid);
    check("tdata_pkt4", int'(tdata4), m_data);
    check("tlast_pkt4", int'(tlast4), m_last4);
    check("seed_ready_pkt4", int'(seed_ready4), exp_ready);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int d, ns, s, first_return;
    int beats[0:255];

    // Pin the model against hand-computed values and the expected 255-beat period.
    gen_beat('h2D, d, ns);
    check("model_first_beat", d, 'h1D);
    check("model_state_after", ns, 'h18);
    s = 'h2D;
    first_return = -1;
    for (int k = 0; k < 256; k++) begin
      gen_beat(s, d, ns);
      beats[k] = d;
      s = ns;
      if (s == 'h2D && first_return < 0) first_return = k + 1;
    end
    check("model_period", first_return, 255);
    check("model_beat255", beats[255], 'h1D);

    // Reset state.
    repeat (3) tick();
    check("rst_tvalid", int'(tvalid0), 0);
    check("rst_tdata", int'(tdata0), 0);
    check("rst_seed_ready", int'(seed_ready0), 1);

    // Stream from reset.
    reset = 1'b0; enable = 1'b1; tready = 1'b1;
    tick();
    check("first_tvalid", int'(tvalid0), 1);
    check("first_tdata", int'(tdata0), 'h1D);
    repeat (3) tick();
    check("tlast_beat3", int'(tlast4), 1);
    repeat (252) tick();
    check("beat255_tdata", int'(tdata0), 'h1D);
    check("beat255_tlast", int'(tlast4), 1);
    repeat (300) tick();

    // Reseed with zero while idle, then hold the beat in a stall and ignore seed pulses.
    enable = 1'b0;
    tick();
    seed_load = 1'b1; seed_data = 8'h00;
    tick();
    seed_load = 1'b0; enable = 1'b1; tready = 1'b0;
    tick();
    check("stall_first_tdata", int'(tdata0), 'h1D);
    for (int c = 0; c < 5; c++) begin
      seed_load = ($urandom_range(0, 1) == 1);
      seed_data = 8'($urandom_range(0, 255));
      tick();
      check("stall_tdata", int'(tdata0), 'h1D);
      check("stall_seed_ready", int'(seed_ready0), 0);
    end
    seed_load = 1'b0; enable = 1'b0; tready = 1'b1;
    tick();
    check("stall_release_tvalid", int'(tvalid0), 0);

    // Reseed with 0x2D in mid-stream. Packet counting restarts.
    enable = 1'b1;
    repeat (10) tick();
    seed_load = 1'b1; seed_data = 8'h2D;
    tick();
    seed_load = 1'b0;
    tick();
    check("reseed_tdata", int'(tdata0), 'h1D);
    check("reseed_beat0_tlast", int'(tlast4), 0);
    repeat (3) tick();
    check("reseed_beat3_tlast", int'(tlast4), 1);

    // Drop enable, stall, then apply reset during the stall.
    repeat (5) tick();
    enable = 1'b0; tready = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rst_stall_tvalid", int'(tvalid0), 0);
    reset = 1'b0; enable = 1'b1; tready = 1'b1;
    tick();
    check("restart_tdata", int'(tdata0), 'h1D);
    check("restart_tlast", int'(tlast4), 0);

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 9) != 0);
      tready    = ($urandom_range(0, 3) != 0);
      seed_load = ($urandom_range(0, 19) == 0);
      seed_data = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
